// File: rtl/n101_subsys_ahb_bpty_mon.sv
// n101_subsys_ahb_bpty_mon: AHB-Lite bus parity generator/checker with error log; optional error counter under N101_BPTY_ERR_CNT_EN
module n101_subsys_ahb_bpty_mon #(
  parameter int ADDR_SIZE  = 32,
  parameter int DATA_WIDTH = 32,
  parameter int PGRP       = 8,
  localparam int NA = (ADDR_SIZE + PGRP - 1) / PGRP,
  localparam int ND = DATA_WIDTH / PGRP
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  bptylvl,
  input  logic [1:0]            htrans,
  input  logic                  hwrite,
  input  logic                  hmastlock,
  input  logic [2:0]            hsize,
  input  logic [2:0]            hburst,
  input  logic [3:0]            hprot,
  input  logic [ADDR_SIZE-1:0]  haddr,
  input  logic [DATA_WIDTH-1:0] hwdata,
  input  logic [DATA_WIDTH-1:0] hrdata,
  input  logic [1:0]            hresp,
  input  logic                  hready,
  input  logic [1:0]            hcmdbpty,
  input  logic [NA-1:0]         haddrbpty,
  input  logic [ND-1:0]         hwdatabpty,
  output logic [ND-1:0]         hrdatabpty,
  output logic                  hrspbpty,
  input  logic                  err_clr,
  output logic                  err_vld,
  output logic                  err_ovf,
  output logic [2:0]            err_type,
  output logic [ADDR_SIZE-1:0]  err_addr,
`ifdef N101_BPTY_ERR_CNT_EN
  output logic [7:0]            err_cnt,
`endif
  output logic                  bpty_fatal
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LOGGED = 2'd1;
  localparam logic [1:0] OVF    = 2'd2;
  logic [1:0]           state, nxt;
  logic                 wr_ph, acc, cmd_bad, addr_bad, wd_bad, ev, cap;
  logic [ADDR_SIZE-1:0] wr_addr;
  logic [NA*PGRP-1:0]   addr_pad;
  assign addr_pad = (NA*PGRP)'(haddr);
  assign acc      = htrans[1] & hready;
  assign hrspbpty = (^{hresp, hready}) ^ bptylvl;
  // read-data parity generation and per-group address/write-data checks
  always_comb begin
    hrdatabpty = '0;
    addr_bad   = 1'b0;
    wd_bad     = 1'b0;
    for (int i = 0; i < ND; i++) begin
      hrdatabpty[i] = (^hrdata[i*PGRP +: PGRP]) ^ bptylvl;
      wd_bad        = wd_bad | ((^hwdata[i*PGRP +: PGRP]) ^ hwdatabpty[i] ^ bptylvl);
    end
    for (int i = 0; i < NA; i++)
      addr_bad = addr_bad | ((^addr_pad[i*PGRP +: PGRP]) ^ haddrbpty[i] ^ bptylvl);
  end
  assign cmd_bad = acc & (((^{htrans, hwrite, hmastlock}) ^ hcmdbpty[0] ^ bptylvl) |
                          ((^{hsize, hburst, hprot}) ^ hcmdbpty[1] ^ bptylvl));
  assign ev  = cmd_bad | (acc & addr_bad) | (wr_ph & hready & wd_bad);
  assign cap = ev & (err_clr | state == IDLE);
  assign nxt = ev ? ((err_clr || state == IDLE) ? LOGGED : OVF) : (err_clr ? IDLE : state);
  assign err_vld = state != IDLE;
  assign err_ovf = state == OVF;
  // write data-phase tracking: set on accepted write, held while hready is low
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ph   <= 1'b0;
      wr_addr <= '0;
    end else if (hready) begin
      wr_ph   <= acc & hwrite;
      wr_addr <= (acc & hwrite) ? haddr : wr_addr;
    end
  // error log FSM, first-error capture and sticky fatal flag
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= IDLE;
      err_type   <= '0;
      err_addr   <= '0;
      bpty_fatal <= 1'b0;
    end else begin
      state      <= nxt;
      err_type   <= cap ? {wr_ph & hready & wd_bad, acc & addr_bad, cmd_bad} : err_type;
      err_addr   <= cap ? ((cmd_bad | (acc & addr_bad)) ? haddr : wr_addr) : err_addr;
      bpty_fatal <= bpty_fatal | cmd_bad | (nxt == OVF);
    end
`ifdef N101_BPTY_ERR_CNT_EN
  // saturating event counter; a clear coinciding with an event restarts at one
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) err_cnt <= '0;
    else        err_cnt <= err_clr ? {7'd0, ev} : ((ev && err_cnt != 8'hFF) ? err_cnt + 8'd1 : err_cnt);
`endif
endmodule

// File: tb/tb_n101_subsys_ahb_bpty_mon.sv
// tb_n101_subsys_ahb_bpty_mon: directed table and sequence checks for the bus parity monitor
module tb_n101_subsys_ahb_bpty_mon;
  logic        clk = 1'b0, rst_n = 1'b0, bptylvl = 1'b0;
  logic [1:0]  htrans = '0, hresp = '0;
  logic        hwrite = 1'b0, hmastlock = 1'b0, hready = 1'b1, err_clr = 1'b0;
  logic [2:0]  hsize = 3'd2, hburst = '0;
  logic [3:0]  hprot = 4'h3;
  logic [31:0] haddr = '0, hwdata = '0, hrdata = '0;
  logic [1:0]  hcmdbpty, cflip = '0;
  logic [3:0]  haddrbpty, hwdatabpty, hrdatabpty, aflip = '0, wflip = '0;
  logic        hrspbpty, err_vld, err_ovf, bpty_fatal;
  logic [2:0]  err_type;
  logic [31:0] err_addr;
`ifdef N101_BPTY_ERR_CNT_EN
  logic [7:0]  err_cnt;
`endif
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  // correct parity for current fields, with deliberate fault masks applied
  always_comb begin
    hcmdbpty = {(^{hsize, hburst, hprot}) ^ bptylvl, (^{htrans, hwrite, hmastlock}) ^ bptylvl} ^ cflip;
    for (int i = 0; i < 4; i++) begin
      haddrbpty[i]  = (^haddr[i*8 +: 8]) ^ bptylvl ^ aflip[i];
      hwdatabpty[i] = (^hwdata[i*8 +: 8]) ^ bptylvl ^ wflip[i];
    end
  end

  n101_subsys_ahb_bpty_mon dut (
    .clk(clk), .rst_n(rst_n), .bptylvl(bptylvl), .htrans(htrans), .hwrite(hwrite),
    .hmastlock(hmastlock), .hsize(hsize), .hburst(hburst), .hprot(hprot), .haddr(haddr),
    .hwdata(hwdata), .hrdata(hrdata), .hresp(hresp), .hready(hready), .hcmdbpty(hcmdbpty),
    .haddrbpty(haddrbpty), .hwdatabpty(hwdatabpty), .hrdatabpty(hrdatabpty), .hrspbpty(hrspbpty),
    .err_clr(err_clr), .err_vld(err_vld), .err_ovf(err_ovf), .err_type(err_type), .err_addr(err_addr),
`ifdef N101_BPTY_ERR_CNT_EN
    .err_cnt(err_cnt),
`endif
    .bpty_fatal(bpty_fatal));

  typedef struct {
    logic lvl; logic [31:0] rd; logic [1:0] rsp; logic rdy; logic [3:0] e_rd; logic e_rsp;
  } vec_t;
  vec_t tv[5];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    htrans = 2'b00; hwrite = 1'b0; cflip = '0; aflip = '0; wflip = '0; err_clr = 1'b0; hready = 1'b1;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    cyc();
  endtask

  initial begin
    tv[0] = '{1'b1, 32'h0000_0001, 2'b00, 1'b1, 4'b1110, 1'b0};
    tv[1] = '{1'b0, 32'h0000_0001, 2'b00, 1'b1, 4'b0001, 1'b1};
    tv[2] = '{1'b0, 32'hFF03_0180, 2'b01, 1'b1, 4'b0011, 1'b0};
    tv[3] = '{1'b1, 32'hFF03_0180, 2'b01, 1'b1, 4'b1100, 1'b1};
    tv[4] = '{1'b1, 32'h0000_0000, 2'b11, 1'b0, 4'b1111, 1'b1};
    for (int i = 0; i < 5; i++) begin
      bptylvl = tv[i].lvl; hrdata = tv[i].rd; hresp = tv[i].rsp; hready = tv[i].rdy;
      #1;
      chk($sformatf("hrdatabpty[%0d]", i), 64'(hrdatabpty), 64'(tv[i].e_rd));
      chk($sformatf("hrspbpty[%0d]", i), 64'(hrspbpty), 64'(tv[i].e_rsp));
    end
    bptylvl = 1'b0; hresp = '0; hready = 1'b1;
    cyc();
    chk("rst err_vld", 64'(err_vld), 0);
    chk("rst err_ovf", 64'(err_ovf), 0);
    chk("rst err_type", 64'(err_type), 0);
    chk("rst err_addr", 64'(err_addr), 0);
    chk("rst fatal", 64'(bpty_fatal), 0);
    rst_n = 1'b1;
    cyc();
    // bad address parity on a NONSEQ read
    htrans = 2'b10; haddr = 32'h8000_0010; aflip = 4'b0001;
    cyc();
    chk("addr err_vld", 64'(err_vld), 1);
    chk("addr err_type", 64'(err_type), 64'b010);
    chk("addr err_addr", 64'(err_addr), 64'h8000_0010);
    chk("addr fatal", 64'(bpty_fatal), 0);
    chk("addr err_ovf", 64'(err_ovf), 0);
    idle(); err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    chk("clr err_vld", 64'(err_vld), 0);
    // write data check deferred across wait states
    htrans = 2'b10; hwrite = 1'b1; haddr = 32'h40; hwdata = 32'hA5A5_0F0F;
    cyc();
    idle(); hready = 1'b0; wflip = 4'b1000;
    cyc();
    chk("wait1 err_vld", 64'(err_vld), 0);
    cyc();
    chk("wait2 err_vld", 64'(err_vld), 0);
    hready = 1'b1;
    cyc();
    chk("wdata err_vld", 64'(err_vld), 1);
    chk("wdata err_type", 64'(err_type), 64'b100);
    chk("wdata err_addr", 64'(err_addr), 64'h40);
    cyc();
    chk("wdata once err_ovf", 64'(err_ovf), 0);
    idle(); err_clr = 1'b1;
    cyc();
    idle();
    // reset in the middle of a stalled write data phase discards the check
    htrans = 2'b10; hwrite = 1'b1; haddr = 32'h80;
    cyc();
    idle(); hready = 1'b0; wflip = 4'b0001;
    cyc();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    hready = 1'b1;
    cyc();
    chk("rstmid err_vld a", 64'(err_vld), 0);
    cyc();
    chk("rstmid err_vld b", 64'(err_vld), 0);
    idle();
    cyc();
    // two consecutive address errors: log then overflow
    htrans = 2'b10; haddr = 32'h100; aflip = 4'b0010;
    cyc();
    chk("ovf1 err_vld", 64'(err_vld), 1);
    chk("ovf1 err_ovf", 64'(err_ovf), 0);
    chk("ovf1 fatal", 64'(bpty_fatal), 0);
    haddr = 32'h200;
    cyc();
    chk("ovf2 err_ovf", 64'(err_ovf), 1);
    chk("ovf2 err_addr", 64'(err_addr), 64'h100);
    chk("ovf2 fatal", 64'(bpty_fatal), 1);
    haddr = 32'h300; err_clr = 1'b1;
    cyc();
    chk("clr+ev err_vld", 64'(err_vld), 1);
    chk("clr+ev err_ovf", 64'(err_ovf), 0);
    chk("clr+ev err_addr", 64'(err_addr), 64'h300);
    idle(); err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    chk("clr err_vld2", 64'(err_vld), 0);
    chk("clr fatal sticky", 64'(bpty_fatal), 1);
    // command parity: ignored when idle or stalled, fatal when accepted
    do_reset();
    chk("rst2 fatal", 64'(bpty_fatal), 0);
    cflip = 2'b10; haddr = 32'h44;
    cyc();
    chk("cmd idle err_vld", 64'(err_vld), 0);
    htrans = 2'b10; hready = 1'b0; aflip = 4'b0100;
    cyc();
    chk("cmd stall err_vld", 64'(err_vld), 0);
    chk("cmd stall fatal", 64'(bpty_fatal), 0);
    hready = 1'b1; aflip = '0;
    cyc();
    chk("cmd err_type", 64'(err_type), 64'b001);
    chk("cmd err_addr", 64'(err_addr), 64'h44);
    chk("cmd fatal", 64'(bpty_fatal), 1);
`ifdef N101_BPTY_ERR_CNT_EN
    do_reset();
    chk("cnt rst", 64'(err_cnt), 0);
    htrans = 2'b10; haddr = 32'h500; aflip = 4'b0001;
    for (int i = 0; i < 300; i++) cyc();
    chk("cnt sat", 64'(err_cnt), 255);
    err_clr = 1'b1;
    cyc();
    chk("cnt clr+ev", 64'(err_cnt), 1);
    chk("cnt clr+ev err_ovf", 64'(err_ovf), 0);
    idle();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/n101_subsys_ahb_bpty_mon.md
N101_SUBSYS_AHB_BPTY_MON -- requirements
Module: n101_subsys_ahb_bpty_mon

Interface
REQ-001 Parameter ADDR_SIZE, default 32: haddr width.
REQ-002 Parameter DATA_WIDTH, default 32: hwdata/hrdata width; SHALL be a multiple of PGRP.
REQ-003 Parameter PGRP, default 8: bits per parity group. NA = ceil(ADDR_SIZE/PGRP); ND = DATA_WIDTH/PGRP.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 bptylvl  in  1  parity sense: 0 even, 1 odd.
REQ-007 htrans[1:0], hwrite, hmastlock, hsize[2:0], hburst[2:0], hprot[3:0]  in  AHB-Lite command.
REQ-008 haddr  in  ADDR_SIZE;  hwdata  in  DATA_WIDTH;  hrdata  in  DATA_WIDTH;  hresp[1:0], hready  in.
REQ-009 hcmdbpty  in  2  [0] covers {htrans,hwrite,hmastlock}; [1] covers {hsize,hburst,hprot}.
REQ-010 haddrbpty  in  NA;  hwdatabpty  in  ND  per-group parity, group i = bits [i*PGRP +: PGRP], top address group zero-padded.
REQ-011 hrdatabpty  out  ND;  hrspbpty  out  1  generated parity over hrdata groups / {hresp,hready}.
REQ-012 err_clr  in  1  clears logged error (single-cycle pulse).
REQ-013 err_vld  out  1;  err_ovf  out  1;  err_type[2:0]  out  {wdata,addr,cmd};  err_addr  out  ADDR_SIZE.
REQ-014 bpty_fatal  out  1  registered fatal indication.

Function
REQ-015 Parity bit p for a field SHALL satisfy XOR(field) ^ p == bptylvl.
REQ-016 hrdatabpty and hrspbpty SHALL be combinational from current inputs, zero latency.
REQ-017 Address phase accepted when htrans[1] & hready; cmd and addr parity SHALL be checked only in that cycle.
REQ-018 On accepted write, haddr SHALL be registered and a write data-phase flag set; hwdata parity SHALL be checked in the cycle the flag is set and hready is 1; flag clears on that cycle unless a new write is accepted.
REQ-019 hready=0 during data phase SHALL hold the flag and defer the wdata check.
REQ-020 Error event = any of cmd/addr/wdata mismatch in a cycle; err_type bits OR'ed for that cycle; err_addr = haddr (cmd/addr) or registered data-phase address (wdata only).
REQ-021 FSM states IDLE, LOGGED, OVF; IDLE->LOGGED on event (capture type/addr); LOGGED->OVF on further event (capture NOT updated); LOGGED/OVF->IDLE on err_clr without event.
REQ-022 err_clr and event same cycle SHALL go to LOGGED with new capture, err_ovf cleared.
REQ-023 err_vld = state!=IDLE; err_ovf = state==OVF; both registered, asserted one cycle after event.
REQ-024 bpty_fatal SHALL assert the cycle after entering OVF or after any cmd parity error, and stays set until reset (err_clr does not clear it).
REQ-025 htrans IDLE/BUSY or hready=0 address cycles SHALL never produce events.

Reset
REQ-026 rst_n low SHALL asynchronously force state IDLE, data-phase flag 0, err_type 0, err_addr 0, bpty_fatal 0, err_cnt 0.
REQ-027 Reset asserted mid data phase SHALL drop the pending wdata check; no event after release for that transfer.

Configuration
REQ-028 Macro N101_BPTY_ERR_CNT_EN defined: output err_cnt[7:0] counts error events, saturates at 255, cleared by err_clr (event in same cycle -> 1).
REQ-029 N101_BPTY_ERR_CNT_EN undefined: err_cnt port and counter SHALL not exist; all other behaviour identical.

Verification
REQ-030 bptylvl=1, hrdata=32'h0000_0001 -> hrdatabpty=4'b1110; hresp=0,hready=1 -> hrspbpty=0.
REQ-031 NONSEQ read haddr=32'h8000_0010, haddrbpty[0] flipped -> next cycle err_vld=1, err_type=3'b010, err_addr=32'h8000_0010, bpty_fatal=0.
REQ-032 Write haddr=32'h40, hready=0 two data cycles then 1 with bad hwdatabpty[3] -> error only after hready=1, err_type=3'b100, err_addr=32'h40.
REQ-033 Two addr errors in consecutive transfers -> LOGGED then OVF, err_addr holds first address, bpty_fatal=1 next cycle, err_clr -> err_vld=0, bpty_fatal stays 1.
REQ-034 Bad hcmdbpty[1] with htrans=2'b00 -> no event; same with htrans=2'b10 -> err_type=3'b001, bpty_fatal=1.
REQ-035 With N101_BPTY_ERR_CNT_EN: 300 addr errors -> err_cnt=255; err_clr coincident with error -> err_cnt=1, err_ovf=0.
